// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared definitions for the register-file write-port arbiter.
//   - DW / AW     : default data and register-address widths
//   - REQ_ALU/MEM : requester identifiers used by the round-robin pointer
//   - wr_req_t    : one pending writeback {valid, addr, data} at the default
//                   widths, for code that handles whole requests as a unit
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  // Requester identifiers. The round-robin pointer stores the last winner
  // using these values.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage : rf_pkg

// File: rtl/rf_wr_slot.sv
// -----------------------------------------------------------------------------
// rf_wr_slot
//   One-entry holding register for a single writeback requester.
//   A fill loads the slot. A drain (the slot won arbitration) empties it
//   unless a fill lands on the same edge, which keeps full throughput.
//
//   Ports
//     clk, rst_n    clock / asynchronous active-low reset
//     fill_i        load fill_addr_i / fill_data_i into the slot this edge
//     fill_addr_i   destination register of the incoming request
//     fill_data_i   write data of the incoming request
//     drain_i       slot contents are being issued to the output register
//     occupied_o    slot holds a pending write
//     addr_o        pending destination register
//     data_o        pending write data
// -----------------------------------------------------------------------------
module rf_wr_slot #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          drain_i,
  output logic          occupied_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          occupied_q, occupied_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] data_q,     data_d;

  always_comb begin
    // NOTE: every always_comb output gets a hold value first, so any path
    // that does not assign it cannot infer a latch.
    occupied_d = occupied_q;
    addr_d     = addr_q;
    data_d     = data_q;
    if (fill_i) begin
      // A fill wins over a simultaneous drain: the old entry leaves through
      // the output register while the new one takes its place.
      occupied_d = 1'b1;
      addr_d     = fill_addr_i;
      data_d     = fill_data_i;
    end else if (drain_i) begin
      occupied_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied_q <= 1'b0;
      // NOTE: the payload is reset as well. It is only one word, and a
      // known value keeps the hazard compare and simulation free of X.
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples its _d value from before the edge.
      occupied_q <= occupied_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign occupied_o = occupied_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

endmodule : rf_wr_slot

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
//   Shares the single register-file write port between the ALU writeback and
//   the memory-load writeback. Each requester has a one-entry slot with a
//   valid/ready handshake. One occupied slot is granted per cycle, and the
//   grant is registered onto Awr/Din/WrEn.
//   - Different destinations: round-robin against the last winner.
//   - Same destination: the older slot wins, so program order is kept.
//   Writes to register 0 are accepted and dropped.
//   Read-after-write hazards are flagged for two decode read addresses.
//
//   Ports
//     Clk, Rst_n                    clock / asynchronous active-low reset
//     AluValid/AluAddr/AluData      ALU writeback request
//     AluReady                      ALU slot can accept this cycle
//     MemValid/MemAddr/MemData      load writeback request
//     MemReady                      load slot can accept this cycle
//     Ard1, Ard2                    decode read addresses (hazard check only)
//     Haz1, Haz2                    read address has an uncommitted write
//     Awr, Din, WrEn                registered write port to reg_file
// -----------------------------------------------------------------------------
module rf_wr_arbiter #(
  parameter int DW = rf_pkg::DW,
  parameter int AW = rf_pkg::AW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          AluValid,
  input  logic [AW-1:0] AluAddr,
  input  logic [DW-1:0] AluData,
  output logic          AluReady,
  input  logic          MemValid,
  input  logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemData,
  output logic          MemReady,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic          Haz1,
  output logic          Haz2,
  output logic [AW-1:0] Awr,
  output logic [DW-1:0] Din,
  output logic          WrEn
);

  import rf_pkg::*;

  // ---------------------------------------------------------------------------
  // Holding slots
  // ---------------------------------------------------------------------------
  logic          alu_occ,  mem_occ;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_gnt,  mem_gnt;
  logic          alu_fill, mem_fill;

  // An address-0 request still completes its handshake, but it never
  // occupies the slot.
  assign alu_fill = AluValid && AluReady && (AluAddr != '0);
  assign mem_fill = MemValid && MemReady && (MemAddr != '0);

  rf_wr_slot #(.DW(DW), .AW(AW)) u_alu_slot (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .fill_i      (alu_fill),
    .fill_addr_i (AluAddr),
    .fill_data_i (AluData),
    .drain_i     (alu_gnt),
    .occupied_o  (alu_occ),
    .addr_o      (alu_addr),
    .data_o      (alu_data)
  );

  rf_wr_slot #(.DW(DW), .AW(AW)) u_mem_slot (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .fill_i      (mem_fill),
    .fill_addr_i (MemAddr),
    .fill_data_i (MemData),
    .drain_i     (mem_gnt),
    .occupied_o  (mem_occ),
    .addr_o      (mem_addr),
    .data_o      (mem_data)
  );

  // The grant depends only on slot state, never on the incoming valid.
  // Ready therefore has no combinational path from Valid.
  assign AluReady = !alu_occ || alu_gnt;
  assign MemReady = !mem_occ || mem_gnt;

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  logic last_q,      last_d;       // last winner, REQ_ALU / REQ_MEM
  logic alu_older_q, alu_older_d;  // meaningful only while both slots are full

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (alu_occ && mem_occ) begin
      if (alu_addr == mem_addr) begin
        // Same destination: issue in arrival order, so the younger value is
        // the one left in the register.
        alu_gnt = alu_older_q;
        mem_gnt = !alu_older_q;
      end else if (last_q == REQ_ALU) begin
        mem_gnt = 1'b1;
      end else begin
        alu_gnt = 1'b1;
      end
    end else begin
      alu_gnt = alu_occ;
      mem_gnt = mem_occ;
    end
  end

  always_comb begin
    last_d = last_q;
    if (alu_gnt) begin
      last_d = REQ_ALU;
    end else if (mem_gnt) begin
      last_d = REQ_MEM;
    end
  end

  // Age tracking. A slot filled while the other one stays occupied is the
  // younger slot. When both fill on the same edge, the ALU counts as older.
  // A fill into an empty pair leaves only one slot occupied, so the flag
  // value does not matter then.
  always_comb begin
    alu_older_d = alu_older_q;
    if (alu_fill && mem_fill) begin
      alu_older_d = 1'b1;
    end else if (alu_fill) begin
      alu_older_d = 1'b0;
    end else if (mem_fill) begin
      alu_older_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] awr_q,   awr_d;
  logic [DW-1:0] din_q,   din_d;

  always_comb begin
    wr_en_d = alu_gnt || mem_gnt;
    awr_d   = awr_q;
    din_d   = din_q;
    if (alu_gnt) begin
      awr_d = alu_addr;
      din_d = alu_data;
    end else if (mem_gnt) begin
      awr_d = mem_addr;
      din_d = mem_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_q      <= REQ_ALU;
      alu_older_q <= 1'b1;
      wr_en_q     <= 1'b0;
      awr_q       <= '0;
      din_q       <= '0;
    end else begin
      last_q      <= last_d;
      alu_older_q <= alu_older_d;
      wr_en_q     <= wr_en_d;
      awr_q       <= awr_d;
      din_q       <= din_d;
    end
  end

  assign WrEn = wr_en_q;
  assign Awr  = awr_q;
  assign Din  = din_q;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // A write is uncommitted while it sits in a slot or in the output register.
  // The register file commits it on the edge that ends the WrEn cycle.
  // Register 0 never carries a hazard.
  // ---------------------------------------------------------------------------
  assign Haz1 = (Ard1 != '0) &&
                ((alu_occ && (alu_addr == Ard1)) ||
                 (mem_occ && (mem_addr == Ard1)) ||
                 (wr_en_q && (awr_q    == Ard1)));

  assign Haz2 = (Ard2 != '0) &&
                ((alu_occ && (alu_addr == Ard2)) ||
                 (mem_occ && (mem_addr == Ard2)) ||
                 (wr_en_q && (awr_q    == Ard2)));

endmodule : rf_wr_arbiter

// File: tb/tb_rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wr_arbiter
//   Self-checking bench for rf_wr_arbiter. A reference model holds each
//   pending write with an arrival stamp, and a shadow register file shows
//   what reg_file would contain. A table of hand-derived vectors covers the
//   basic scenarios. Hand sequences cover sustained traffic and a reset
//   arriving mid-transfer. A randomized run compares the DUT with the model.
// -----------------------------------------------------------------------------
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        AluValid, MemValid;
  logic [4:0]  AluAddr, MemAddr, Ard1, Ard2, Awr;
  logic [31:0] AluData, MemData, Din;
  logic        AluReady, MemReady, Haz1, Haz2, WrEn;

  rf_wr_arbiter #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .Ard1(Ard1), .Ard2(Ard2), .Haz1(Haz1), .Haz2(Haz2),
    .Awr(Awr), .Din(Din), .WrEn(WrEn)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Shadow reg_file. It commits whatever the DUT drives on the write port.
  logic [31:0] rf_mem [32];
  always @(posedge Clk) if (WrEn && (Awr != 5'd0)) rf_mem[Awr] <= Din;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a pending write per requester (index 0 = ALU, 1 = Mem)
  // plus an arrival stamp. A lower stamp means an earlier arrival.
  // ---------------------------------------------------------------------------
  wr_req_t     m_slot [2];
  int          m_age  [2];
  int          m_seq;
  int          m_last;          // index of last winner
  logic        m_wren;
  logic [4:0]  m_awr;
  logic [31:0] m_din;
  logic [31:0] exp_rf [32];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_slot[k] = '0;
      m_age[k]  = 0;
    end
    m_last = 0;
    m_wren = 1'b0;
    m_awr  = '0;
    m_din  = '0;
  endtask

  function automatic int winner();
    if (m_slot[0].valid && m_slot[1].valid) begin
      if (m_slot[0].addr == m_slot[1].addr) return (m_age[0] < m_age[1]) ? 0 : 1;
      return (m_last == 0) ? 1 : 0;
    end
    if (m_slot[0].valid) return 0;
    if (m_slot[1].valid) return 1;
    return -1;
  endfunction

  function automatic logic model_haz(input logic [4:0] ard);
    if (ard == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (m_slot[k].valid && m_slot[k].addr == ard) return 1'b1;
    return m_wren && (m_awr == ard);
  endfunction

  typedef struct packed {
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ardy; logic e_mrdy; logic e_wren;
    logic [4:0]  e_awr;  logic [31:0] e_din;
    logic        e_h1;   logic e_h2;
  } vec_t;

  typedef struct packed { logic we; logic [4:0] awr; logic [31:0] din; } obs_t;

  obs_t obs[$];
  bit   rec_en = 1'b0;
  bit   g_ardy, g_mrdy;

  // One clock cycle. Inputs are applied just after the rising edge. Outputs
  // are checked on the falling edge against the model and, when has_exp is
  // set, against the vector's own expectations. The model then advances
  // across the next rising edge.
  task automatic run_cycle(input vec_t v, input bit has_exp, input string tag);
    int   w;
    logic ea, em;
    AluValid = v.av; AluAddr = v.aa; AluData = v.ad;
    MemValid = v.mv; MemAddr = v.ma; MemData = v.md;
    Ard1 = v.r1; Ard2 = v.r2;
    @(negedge Clk);
    w  = winner();
    ea = !m_slot[0].valid || (w == 0);
    em = !m_slot[1].valid || (w == 1);
    check({tag, ".m_alu_ready"}, 32'(AluReady), 32'(ea));
    check({tag, ".m_mem_ready"}, 32'(MemReady), 32'(em));
    check({tag, ".m_wren"},      32'(WrEn),     32'(m_wren));
    check({tag, ".m_awr"},       32'(Awr),      32'(m_awr));
    check({tag, ".m_din"},       Din,           m_din);
    check({tag, ".m_haz1"},      32'(Haz1),     32'(model_haz(v.r1)));
    check({tag, ".m_haz2"},      32'(Haz2),     32'(model_haz(v.r2)));
    if (has_exp) begin
      check({tag, ".t_alu_ready"}, 32'(AluReady), 32'(v.e_ardy));
      check({tag, ".t_mem_ready"}, 32'(MemReady), 32'(v.e_mrdy));
      check({tag, ".t_wren"},      32'(WrEn),     32'(v.e_wren));
      check({tag, ".t_awr"},       32'(Awr),      32'(v.e_awr));
      check({tag, ".t_din"},       Din,           v.e_din);
      check({tag, ".t_haz1"},      32'(Haz1),     32'(v.e_h1));
      check({tag, ".t_haz2"},      32'(Haz2),     32'(v.e_h2));
    end
    g_ardy = AluReady;
    g_mrdy = MemReady;
    if (rec_en) obs.push_back('{WrEn, Awr, Din});
    // Model update for the coming edge: commit, grant, then accepts.
    // The ALU is stamped first, so it counts as older on a same-edge fill.
    if (m_wren && m_awr != 5'd0) exp_rf[m_awr] = m_din;
    m_wren = (w >= 0);
    if (w >= 0) begin
      m_awr  = m_slot[w].addr;
      m_din  = m_slot[w].data;
      m_last = w;
      m_slot[w].valid = 1'b0;
    end
    if (v.av && ea && v.aa != 5'd0) begin
      m_slot[0] = '{1'b1, v.aa, v.ad}; m_age[0] = m_seq; m_seq++;
    end
    if (v.mv && em && v.ma != 5'd0) begin
      m_slot[1] = '{1'b1, v.ma, v.md}; m_age[1] = m_seq; m_seq++;
    end
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl [20];

  task automatic fill_table();
    //          av   aa     ad            mv   ma     md            r1     r2     ar   mr   we   awr    din           h1   h2
    // Single ALU write to r3, with a hazard until its commit
    tbl[0]  = '{1'b1,5'd3, 32'd32,       1'b0,5'd0, 32'd0,        5'd3, 5'd0, 1'b1,1'b1,1'b0,5'd0, 32'd0,        1'b0,1'b0};
    tbl[1]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd3, 5'd0, 1'b1,1'b1,1'b0,5'd0, 32'd0,        1'b1,1'b0};
    tbl[2]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd3, 5'd0, 1'b1,1'b1,1'b1,5'd3, 32'd32,       1'b1,1'b0};
    tbl[3]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd3, 5'd0, 1'b1,1'b1,1'b0,5'd3, 32'd32,       1'b0,1'b0};
    // Same-edge requests to different registers: round-robin, Mem first
    tbl[4]  = '{1'b1,5'd10,32'd2,        1'b1,5'd11,32'd7,        5'd10,5'd11,1'b1,1'b1,1'b0,5'd3, 32'd32,       1'b0,1'b0};
    tbl[5]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b0,1'b1,1'b0,5'd3, 32'd32,       1'b1,1'b1};
    tbl[6]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b1,1'b1,1'b1,5'd11,32'd7,        1'b1,1'b1};
    tbl[7]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b1,1'b1,1'b1,5'd10,32'd2,        1'b1,1'b0};
    tbl[8]  = '{1'b1,5'd10,32'd4,        1'b1,5'd11,32'd8,        5'd10,5'd11,1'b1,1'b1,1'b0,5'd10,32'd2,        1'b0,1'b0};
    tbl[9]  = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b0,1'b1,1'b0,5'd10,32'd2,        1'b1,1'b1};
    tbl[10] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b1,1'b1,1'b1,5'd11,32'd8,        1'b1,1'b1};
    tbl[11] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd10,5'd11,1'b1,1'b1,1'b1,5'd10,32'd4,        1'b1,1'b0};
    // Same-edge requests to the same register: the older (ALU) slot wins
    // even though round-robin would favour Mem
    tbl[12] = '{1'b1,5'd5, 32'h0000AAAA, 1'b1,5'd5, 32'h00005555, 5'd5, 5'd0, 1'b1,1'b1,1'b0,5'd10,32'd4,        1'b0,1'b0};
    tbl[13] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd5, 5'd0, 1'b1,1'b0,1'b0,5'd10,32'd4,        1'b1,1'b0};
    tbl[14] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd5, 5'd0, 1'b1,1'b1,1'b1,5'd5, 32'h0000AAAA, 1'b1,1'b0};
    tbl[15] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd5, 5'd0, 1'b1,1'b1,1'b1,5'd5, 32'h00005555, 1'b1,1'b0};
    tbl[16] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd5, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h00005555, 1'b0,1'b0};
    // Writes to r0: accepted, then dropped
    tbl[17] = '{1'b1,5'd0, 32'h0000FFFF, 1'b0,5'd0, 32'd0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h00005555, 1'b0,1'b0};
    tbl[18] = '{1'b1,5'd0, 32'h0000FFFF, 1'b0,5'd0, 32'd0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h00005555, 1'b0,1'b0};
    tbl[19] = '{1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd5, 32'h00005555, 1'b0,1'b0};
  endtask

  initial begin
    vec_t v;
    int   a_i, m_i, first, n_we, n_alu, n_mem, a_seen, m_seen;

    for (int r = 0; r < 32; r++) begin
      rf_mem[r] = '0;
      exp_rf[r] = '0;
    end
    m_seq = 0;
    model_reset();
    Rst_n = 1'b0;
    AluValid = 1'b0; AluAddr = '0; AluData = '0;
    MemValid = 1'b0; MemAddr = '0; MemData = '0;
    Ard1 = 5'd3; Ard2 = 5'd5;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_wren",      32'(WrEn),     32'd0);
    check("rst_awr",       32'(Awr),      32'd0);
    check("rst_din",       Din,           32'd0);
    check("rst_alu_ready", 32'(AluReady), 32'd1);
    check("rst_mem_ready", 32'(MemReady), 32'd1);
    check("rst_haz1",      32'(Haz1),     32'd0);
    check("rst_haz2",      32'(Haz2),     32'd0);
    Rst_n = 1'b1;

    // Table-driven directed vectors
    fill_table();
    for (int i = 0; i < 20; i++) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));
    check("rf_r3",  rf_mem[3],  32'd32);
    check("rf_r10", rf_mem[10], 32'd4);
    check("rf_r11", rf_mem[11], 32'd8);
    check("rf_r5",  rf_mem[5],  32'h00005555);
    check("rf_r0",  rf_mem[0],  32'd0);

    // Sustained traffic: both requesters valid for 8 cycles. Each request is
    // held until its handshake completes.
    a_i = 0; m_i = 0;
    obs.delete();
    rec_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      v = '0;
      v.av = 1'b1; v.aa = 5'(12 + a_i); v.ad = 32'hA000 + 32'(a_i);
      v.mv = 1'b1; v.ma = 5'(24 + m_i); v.md = 32'hB000 + 32'(m_i);
      v.r1 = 5'(12 + a_i); v.r2 = 5'(24 + m_i);
      run_cycle(v, 1'b0, "burst");
      if (g_ardy) a_i++;
      if (g_mrdy) m_i++;
    end
    for (int c = 0; c < 5; c++) run_cycle('0, 1'b0, "drain");
    rec_en = 1'b0;

    first = -1;
    for (int k = 0; k < obs.size(); k++) if (first < 0 && obs[k].we) first = k;
    n_we = 0; n_alu = 0; n_mem = 0;
    if (first >= 0) begin
      for (int k = first; k < first + 8 && k < obs.size(); k++) begin
        if (obs[k].we) begin
          n_we++;
          if (obs[k].awr < 5'd24) n_alu++; else n_mem++;
        end
      end
    end
    check("burst_wren_continuous", 32'(n_we),  32'd8);
    check("burst_alu_writes",      32'(n_alu), 32'd4);
    check("burst_mem_writes",      32'(n_mem), 32'd4);
    // Every accepted request is written exactly once, in order per requester
    a_seen = 0; m_seen = 0;
    foreach (obs[k]) begin
      if (obs[k].we && obs[k].awr < 5'd24) begin
        check("burst_alu_data", obs[k].din, 32'hA000 + 32'(a_seen));
        a_seen++;
      end else if (obs[k].we) begin
        check("burst_mem_data", obs[k].din, 32'hB000 + 32'(m_seen));
        m_seen++;
      end
    end
    check("burst_alu_count", 32'(a_seen), 32'(a_i));
    check("burst_mem_count", 32'(m_seen), 32'(m_i));

    // Reset mid-cycle while both slots and the output register are busy
    v = '0;
    v.av = 1'b1; v.aa = 5'd20; v.ad = 32'h20;
    v.mv = 1'b1; v.ma = 5'd21; v.md = 32'h21;
    run_cycle(v, 1'b0, "pre_rst_a");
    v.aa = 5'd22; v.ad = 32'h22; v.ma = 5'd23; v.md = 32'h23;
    run_cycle(v, 1'b0, "pre_rst_b");
    AluValid = 1'b0; MemValid = 1'b0;
    Ard1 = 5'd20; Ard2 = 5'd21;
    #3;
    check("pre_rst_wren", 32'(WrEn), 32'd1);
    check("pre_rst_haz1", 32'(Haz1), 32'd1);
    check("pre_rst_haz2", 32'(Haz2), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_wren", 32'(WrEn), 32'd0);
    check("mid_rst_haz1", 32'(Haz1), 32'd0);
    check("mid_rst_haz2", 32'(Haz2), 32'd0);
    Ard1 = 5'd22; Ard2 = 5'd23;
    #1;
    check("mid_rst_haz1b", 32'(Haz1), 32'd0);
    check("mid_rst_haz2b", 32'(Haz2), 32'd0);
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    obs.delete();
    rec_en = 1'b1;
    v = '0;
    v.r1 = 5'd22; v.r2 = 5'd23;
    for (int c = 0; c < 4; c++) run_cycle(v, 1'b0, "post_rst");
    rec_en = 1'b0;
    n_we = 0;
    foreach (obs[k]) if (obs[k].we) n_we++;
    check("post_rst_no_stale_write", 32'(n_we), 32'd0);

    // Randomized traffic against the model. The small address range forces
    // same-register collisions and register-0 requests.
    for (int c = 0; c < 600; c++) begin
      v = '0;
      v.av = 1'($urandom_range(0, 1));
      v.aa = 5'($urandom_range(0, 7));
      v.ad = $urandom;
      v.mv = 1'($urandom_range(0, 1));
      v.ma = 5'($urandom_range(0, 7));
      v.md = $urandom;
      v.r1 = 5'($urandom_range(0, 7));
      v.r2 = 5'($urandom_range(0, 7));
      run_cycle(v, 1'b0, "rnd");
    end
    for (int c = 0; c < 4; c++) run_cycle('0, 1'b0, "rnd_drain");
    for (int r = 0; r < 32; r++) check($sformatf("final_rf_r%0d", r), rf_mem[r], exp_rf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_wr_arbiter
